s2mm_bram_writer: RTL and testbench

S2MM_BRAM_WRITER -- requirements
Module: s2mm_bram_writer

---
 rtl/dm_s2mm_pkg.sv | 38 +++
 rtl/s2mm_bram_writer.sv | 188 ++++++++++++++++++
 tb/tb_s2mm_bram_writer.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_s2mm_pkg.sv
// rtl/dm_s2mm_pkg.sv - shared command/status field map, FSM states and popcount for the S2MM writer
package dm_s2mm_pkg;

    // Command word field positions (72-bit DataMover command)
    localparam int CMD_W         = 72;
    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_BTT_MSB   = 22;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_SADDR_MSB = 63;
    localparam int CMD_TAG_LSB   = 64;
    localparam int CMD_TAG_MSB   = 67;

    // Status byte field positions
    localparam int STS_TAG_LSB = 0;
    localparam int STS_TAG_MSB = 3;
    localparam int STS_INTERR  = 4;
    localparam int STS_DECERR  = 5;
    localparam int STS_SLVERR  = 6;
    localparam int STS_OKAY    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2,
        STS   = 2'd3
    } state_t;

    // Number of enabled byte lanes in a tkeep vector
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/s2mm_bram_writer.sv
// rtl/s2mm_bram_writer.sv - DataMover-style S2MM command/data to byte-enable BRAM write port with status
module s2mm_bram_writer
    import dm_s2mm_pkg::*;
#(
    parameter int MEM_AW  = 12,
    parameter int TAG_CHK = 1
) (
    input  logic              dm_clk,
    input  logic              dm_rst_n,
    input  logic              i_s2mm_wr_cmd_tvalid,
    output logic              o_s2mm_wr_cmd_tready,
    input  logic [CMD_W-1:0]  i_s2mm_wr_cmd_tdata,
    input  logic [63:0]       i_s2mm_wr_tdata,
    input  logic [7:0]        i_s2mm_wr_tkeep,
    input  logic              i_s2mm_wr_tvalid,
    input  logic              i_s2mm_wr_tlast,
    output logic              o_s2mm_wr_tready,
    output logic [7:0]        o_s2mm_sts_tdata,
    output logic              o_s2mm_sts_tkeep,
    output logic              o_s2mm_sts_tvalid,
    output logic              o_s2mm_sts_tlast,
    input  logic              i_s2mm_sts_tready,
    output logic [7:0]        o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [63:0]       o_mem_wdata,
    output logic [31:0]       o_bytes_total
);

    state_t state, state_next;

    // Holds off command acceptance for the first cycle out of reset
    logic init_done;

    logic [MEM_AW-1:0] ptr;
    logic [22:0]       rem;
    logic [3:0]        tag;
    logic              interr;
    logic              decerr;

    logic [22:0] cmd_btt;
    logic [31:0] cmd_saddr;
    logic [3:0]  cmd_tag;
    logic [23:0] cmd_words;
    logic [33:0] cmd_end;
    logic [33:0] cmd_limit;
    logic        cmd_bad_align;
    logic        cmd_bad_range;
    logic        cmd_fire;
    logic        beat_fire;
    logic        rem_last;
    logic [3:0]  tag_field;
    logic [7:0]  sts_word;
    logic        unused_cmd_bits;

    assign cmd_btt   = i_s2mm_wr_cmd_tdata[CMD_BTT_MSB:CMD_BTT_LSB];
    assign cmd_saddr = i_s2mm_wr_cmd_tdata[CMD_SADDR_MSB:CMD_SADDR_LSB];
    assign cmd_tag   = i_s2mm_wr_cmd_tdata[CMD_TAG_MSB:CMD_TAG_LSB];

    assign unused_cmd_bits = ^{i_s2mm_wr_cmd_tdata[CMD_W-1:CMD_TAG_MSB+1],
                               i_s2mm_wr_cmd_tdata[CMD_SADDR_LSB-1:CMD_BTT_MSB+1]};

    // Range check in 34 bits so a start near the top plus a large BTT cannot wrap
    assign cmd_words     = ({1'b0, cmd_btt} + 24'd7) >> 3;
    assign cmd_end       = {5'd0, cmd_saddr[31:3]} + {10'd0, cmd_words};
    assign cmd_limit     = 34'd1 << MEM_AW;
    assign cmd_bad_align = (cmd_saddr[2:0] != 3'd0) || (cmd_btt == 23'd0);
    assign cmd_bad_range = (cmd_end > cmd_limit);

    assign cmd_fire  = i_s2mm_wr_cmd_tvalid & o_s2mm_wr_cmd_tready;
    assign beat_fire = i_s2mm_wr_tvalid & o_s2mm_wr_tready;
    assign rem_last  = (rem <= 23'd8);

    assign tag_field = (TAG_CHK != 0) ? tag : 4'd0;

    // State register
    always_ff @(posedge dm_clk) begin
        if (!dm_rst_n) begin
            state     <= IDLE;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            init_done <= 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next           = state;
        o_s2mm_wr_cmd_tready = 1'b0;
        o_s2mm_wr_tready     = 1'b0;
        o_s2mm_sts_tvalid    = 1'b0;
        case (state)
            IDLE: begin
                o_s2mm_wr_cmd_tready = init_done;
                if (i_s2mm_wr_cmd_tvalid && init_done) begin
                    if (cmd_bad_align || cmd_bad_range) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                o_s2mm_wr_tready = 1'b1;
                if (i_s2mm_wr_tvalid && (i_s2mm_wr_tlast || rem_last)) begin
                    state_next = STS;
                end
            end
            DRAIN: begin
                o_s2mm_wr_tready = 1'b1;
                if (i_s2mm_wr_tvalid && i_s2mm_wr_tlast) begin
                    state_next = STS;
                end
            end
            STS: begin
                o_s2mm_sts_tvalid = 1'b1;
                if (i_s2mm_sts_tready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status byte, held at zero outside the STS state
    always_comb begin
        sts_word                          = 8'd0;
        sts_word[STS_TAG_MSB:STS_TAG_LSB] = tag_field;
        sts_word[STS_INTERR]              = interr;
        sts_word[STS_DECERR]              = decerr;
        sts_word[STS_SLVERR]              = 1'b0;
        sts_word[STS_OKAY]                = ~(interr | decerr);
        o_s2mm_sts_tdata                  = o_s2mm_sts_tvalid ? sts_word : 8'd0;
        o_s2mm_sts_tkeep                  = o_s2mm_sts_tvalid;
        o_s2mm_sts_tlast                  = o_s2mm_sts_tvalid;
    end

    // Command latch, word pointer, error flags, memory write port and byte counter
    always_ff @(posedge dm_clk) begin
        if (!dm_rst_n) begin
            ptr           <= '0;
            rem           <= 23'd0;
            tag           <= 4'd0;
            interr        <= 1'b0;
            decerr        <= 1'b0;
            o_mem_we      <= 8'd0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= 64'd0;
            o_bytes_total <= 32'd0;
        end else begin
            o_mem_we <= 8'd0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        ptr    <= cmd_saddr[MEM_AW+2:3];
                        rem    <= cmd_btt;
                        tag    <= cmd_tag;
                        interr <= cmd_bad_align;
                        decerr <= !cmd_bad_align && cmd_bad_range;
                    end
                end
                DATA: begin
                    if (beat_fire) begin
                        o_mem_we      <= i_s2mm_wr_tkeep;
                        o_mem_addr    <= ptr;
                        o_mem_wdata   <= i_s2mm_wr_tdata;
                        ptr           <= ptr + {{(MEM_AW-1){1'b0}}, 1'b1};
                        rem           <= rem_last ? 23'd0 : (rem - 23'd8);
                        o_bytes_total <= o_bytes_total + {28'd0, popcount8(i_s2mm_wr_tkeep)};
                        // Byte budget used up while the stream still claims more data
                        if (rem_last && !i_s2mm_wr_tlast) begin
                            interr <= 1'b1;
                        end
                    end
                end
                STS: begin
                    if (i_s2mm_sts_tready) begin
                        interr <= 1'b0;
                        decerr <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s2mm_bram_writer.sv
// tb/tb_s2mm_bram_writer.sv - scoreboard testbench for s2mm_bram_writer
module tb_s2mm_bram_writer;

    logic        dm_clk = 1'b0;
    logic        dm_rst_n;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [71:0] cmd_tdata;
    logic [63:0] wr_tdata;
    logic [7:0]  wr_tkeep;
    logic        wr_tvalid;
    logic        wr_tlast;
    logic        wr_tready;
    logic [7:0]  sts_tdata;
    logic        sts_tkeep;
    logic        sts_tvalid;
    logic        sts_tlast;
    logic        sts_tready;
    logic [7:0]  mem_we;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [31:0] bytes_total;

    always #5 dm_clk = ~dm_clk;

    s2mm_bram_writer #(.MEM_AW(12), .TAG_CHK(1)) dut (
        .dm_clk               (dm_clk),
        .dm_rst_n             (dm_rst_n),
        .i_s2mm_wr_cmd_tvalid (cmd_tvalid),
        .o_s2mm_wr_cmd_tready (cmd_tready),
        .i_s2mm_wr_cmd_tdata  (cmd_tdata),
        .i_s2mm_wr_tdata      (wr_tdata),
        .i_s2mm_wr_tkeep      (wr_tkeep),
        .i_s2mm_wr_tvalid     (wr_tvalid),
        .i_s2mm_wr_tlast      (wr_tlast),
        .o_s2mm_wr_tready     (wr_tready),
        .o_s2mm_sts_tdata     (sts_tdata),
        .o_s2mm_sts_tkeep     (sts_tkeep),
        .o_s2mm_sts_tvalid    (sts_tvalid),
        .o_s2mm_sts_tlast     (sts_tlast),
        .i_s2mm_sts_tready    (sts_tready),
        .o_mem_we             (mem_we),
        .o_mem_addr           (mem_addr),
        .o_mem_wdata          (mem_wdata),
        .o_bytes_total        (bytes_total)
    );

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  we;
        logic [63:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] sts_q[$];
    wr_t        mon_e;
    int         total = 0;
    int         bad = 0;
    logic [31:0] exp_bytes = 32'd0;
    bit         mon_en = 1'b0;

    // Every nonzero write strobe must match the next expected write
    always @(negedge dm_clk) begin
        if (mon_en && (mem_we !== 8'h00)) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%h we=%h data=%h", mem_addr, mem_we, mem_wdata);
            end else begin
                mon_e = wr_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_we !== mon_e.we || mem_wdata !== mon_e.data) begin
                    bad++;
                    $display("FAIL write got addr=%h we=%h data=%h want addr=%h we=%h data=%h",
                             mem_addr, mem_we, mem_wdata, mon_e.addr, mon_e.we, mon_e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [31:0] saddr, input logic [22:0] btt, input logic [3:0] tag,
                            input logic [7:0] exp_sts, input bit push);
        int n;
        if (push) sts_q.push_back(exp_sts);
        cmd_tdata  = {4'hF, tag, saddr, 9'h1FF, btt};
        cmd_tvalid = 1'b1;
        n = 0;
        @(negedge dm_clk);
        while (cmd_tready !== 1'b1 && n < 100) begin
            @(negedge dm_clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL cmd_handshake timeout saddr=%h", saddr);
        end
        @(posedge dm_clk);
        #1 cmd_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last,
                             input bit wr, input logic [11:0] addr, input int gap);
        int n;
        wr_t e;
        repeat (gap) @(posedge dm_clk);
        #1;
        if (wr) begin
            e.addr = addr;
            e.we   = k;
            e.data = d;
            wr_q.push_back(e);
            exp_bytes = exp_bytes + $countones(k);
        end
        wr_tdata  = d;
        wr_tkeep  = k;
        wr_tlast  = last;
        wr_tvalid = 1'b1;
        n = 0;
        @(negedge dm_clk);
        while (wr_tready !== 1'b1 && n < 100) begin
            @(negedge dm_clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL beat_handshake timeout data=%h", d);
        end
        @(posedge dm_clk);
        #1;
        wr_tvalid = 1'b0;
        wr_tlast  = 1'b0;
    endtask

    task automatic wait_sts(input string name);
        int n;
        logic [7:0] e;
        n = 0;
        @(negedge dm_clk);
        while (sts_tvalid !== 1'b1 && n < 100) begin
            @(negedge dm_clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL %s sts timeout", name);
        end else if (sts_q.size() == 0) begin
            bad++;
            $display("FAIL %s unexpected_status got=%h", name, sts_tdata);
        end else begin
            e = sts_q.pop_front();
            if (sts_tdata !== e || sts_tkeep !== 1'b1 || sts_tlast !== 1'b1) begin
                bad++;
                $display("FAIL %s sts got=%h keep=%b last=%b want=%h keep=1 last=1",
                         name, sts_tdata, sts_tkeep, sts_tlast, e);
            end
        end
        sts_tready = 1'b1;
        @(posedge dm_clk);
        #1 sts_tready = 1'b0;
    endtask

    task automatic test_reset();
        dm_rst_n   = 1'b0;
        cmd_tvalid = 1'b0;
        cmd_tdata  = '0;
        wr_tvalid  = 1'b0;
        wr_tdata   = '0;
        wr_tkeep   = '0;
        wr_tlast   = 1'b0;
        sts_tready = 1'b0;
        repeat (3) @(posedge dm_clk);
        @(negedge dm_clk);
        mon_en = 1'b1;
        total++;
        if ({cmd_tready, wr_tready, sts_tvalid, sts_tkeep, sts_tlast, sts_tdata,
             mem_we, mem_addr, mem_wdata, bytes_total} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got cr=%b wr=%b sv=%b sd=%h we=%h a=%h d=%h bt=%h want all 0",
                     cmd_tready, wr_tready, sts_tvalid, sts_tdata, mem_we, mem_addr, mem_wdata, bytes_total);
        end
        @(posedge dm_clk);
        #1 dm_rst_n = 1'b1;
        exp_bytes = 32'd0;
        @(posedge dm_clk);
        @(negedge dm_clk);
        total++;
        if (cmd_tready !== 1'b1 || wr_tready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got cmd_tready=%b wr_tready=%b want 1 0", cmd_tready, wr_tready);
        end
        @(posedge dm_clk);
        #1;
    endtask

    task automatic test_basic();
        send_cmd(32'h100, 23'd32, 4'd3, 8'h83, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_beat(64'h1111_2222_0000_0000 + 64'(i), 8'hFF, (i == 3), 1'b1, 12'h020 + 12'(i),
                      int'($urandom_range(0, 2)));
        end
        wait_sts("basic");
        @(negedge dm_clk);
        total++;
        if (bytes_total !== exp_bytes || wr_q.size() != 0) begin
            bad++;
            $display("FAIL basic_bytes got=%0d pending=%0d want=%0d pending=0", bytes_total, wr_q.size(), exp_bytes);
        end
        @(posedge dm_clk);
        #1;
    endtask

    task automatic test_partial();
        send_cmd(32'h200, 23'd20, 4'd1, 8'h81, 1'b1);
        send_beat(64'hA5A5_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 12'h040, 0);
        send_beat(64'hA5A5_0000_0000_0002, 8'hFF, 1'b0, 1'b1, 12'h041, 1);
        send_beat(64'hA5A5_0000_0000_0003, 8'h0F, 1'b1, 1'b1, 12'h042, 0);
        wait_sts("partial");
        @(negedge dm_clk);
        total++;
        if (bytes_total !== 32'd52 || bytes_total !== exp_bytes || wr_q.size() != 0) begin
            bad++;
            $display("FAIL partial_bytes got=%0d want=52", bytes_total);
        end
        @(posedge dm_clk);
        #1;
    endtask

    task automatic test_errors();
        // Misaligned start: drained, no writes
        send_cmd(32'h104, 23'd16, 4'd5, 8'h15, 1'b1);
        send_beat(64'hDEAD_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 12'h0, 0);
        send_beat(64'hDEAD_0000_0000_0002, 8'hFF, 1'b1, 1'b0, 12'h0, 0);
        wait_sts("misaligned");
        // Beyond the top of memory
        send_cmd(32'h8000, 23'd8, 4'd2, 8'h22, 1'b1);
        send_beat(64'hDEAD_0000_0000_0003, 8'hFF, 1'b1, 1'b0, 12'h0, 0);
        wait_sts("decerr");
        // Zero byte count
        send_cmd(32'h400, 23'd0, 4'd7, 8'h17, 1'b1);
        send_beat(64'hDEAD_0000_0000_0004, 8'hFF, 1'b1, 1'b0, 12'h0, 0);
        wait_sts("btt_zero");
        // Last word of memory exactly fits
        send_cmd(32'h7FF8, 23'd8, 4'd0, 8'h80, 1'b1);
        send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1, 12'hFFF, 0);
        wait_sts("top_word");
        // One word too far: two words from the last word
        send_cmd(32'h7FF8, 23'd9, 4'd8, 8'h28, 1'b1);
        send_beat(64'hDEAD_0000_0000_0005, 8'hFF, 1'b1, 1'b0, 12'h0, 0);
        wait_sts("top_overflow");
        // Budget runs out without tlast
        send_cmd(32'h500, 23'd8, 4'd4, 8'h14, 1'b1);
        send_beat(64'hBEEF_0000_0000_0001, 8'h3C, 1'b0, 1'b1, 12'h0A0, 0);
        wait_sts("overrun");
        @(negedge dm_clk);
        total++;
        if (bytes_total !== exp_bytes || wr_q.size() != 0) begin
            bad++;
            $display("FAIL errors_bytes got=%0d pending=%0d want=%0d pending=0", bytes_total, wr_q.size(), exp_bytes);
        end
        @(posedge dm_clk);
        #1;
    endtask

    task automatic test_backpressure();
        int n;
        logic [7:0] e;
        send_cmd(32'h80, 23'd8, 4'd6, 8'h86, 1'b1);
        send_beat(64'hCAFE_0000_0000_0001, 8'hFF, 1'b1, 1'b1, 12'h010, 0);
        e = sts_q.pop_front();
        n = 0;
        @(negedge dm_clk);
        while (sts_tvalid !== 1'b1 && n < 100) begin
            @(negedge dm_clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (sts_tvalid !== 1'b1 || sts_tdata !== e || cmd_tready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold cycle=%0d got v=%b d=%h cr=%b want v=1 d=%h cr=0",
                         i, sts_tvalid, sts_tdata, cmd_tready, e);
            end
            @(negedge dm_clk);
        end
        sts_tready = 1'b1;
        @(posedge dm_clk);
        #1 sts_tready = 1'b0;
        @(negedge dm_clk);
        total++;
        if (cmd_tready !== 1'b1 || sts_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_idle got cr=%b v=%b want cr=1 v=0", cmd_tready, sts_tvalid);
        end
        @(posedge dm_clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        send_cmd(32'h300, 23'd32, 4'd9, 8'h00, 1'b0);
        send_beat(64'h7777_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 12'h060, 0);
        wr_tdata  = 64'h7777_0000_0000_0002;
        wr_tkeep  = 8'hFF;
        wr_tvalid = 1'b1;
        dm_rst_n  = 1'b0;
        @(posedge dm_clk);
        #1;
        dm_rst_n  = 1'b1;
        wr_tvalid = 1'b0;
        exp_bytes = 32'd0;
        @(negedge dm_clk);
        total++;
        if ({cmd_tready, wr_tready, sts_tvalid, sts_tkeep, sts_tlast, sts_tdata,
             mem_we, mem_addr, mem_wdata, bytes_total} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got cr=%b wr=%b sv=%b we=%h a=%h d=%h bt=%h want all 0",
                     cmd_tready, wr_tready, sts_tvalid, mem_we, mem_addr, mem_wdata, bytes_total);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge dm_clk);
            if (sts_tvalid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_status got status=%b want 0", seen);
        end
        @(posedge dm_clk);
        #1;
        send_cmd(32'h40, 23'd16, 4'd1, 8'h81, 1'b1);
        send_beat(64'h8888_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 12'h008, 0);
        send_beat(64'h8888_0000_0000_0002, 8'hFF, 1'b1, 1'b1, 12'h009, 2);
        wait_sts("reset_mid_next");
        @(negedge dm_clk);
        total++;
        if (bytes_total !== 32'd16 || wr_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_bytes got=%0d pending=%0d want=16 pending=0", bytes_total, wr_q.size());
        end
        @(posedge dm_clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_errors();
        test_backpressure();
        test_reset_mid();
        repeat (5) @(posedge dm_clk);
        total++;
        if (wr_q.size() != 0 || sts_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected writes=%0d status=%0d want 0 0", wr_q.size(), sts_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
